// File: rtl/memory_access_pkg.sv
// Shared opcode constants and memory-access-type encoding for the MIPS MEM stage.
package memory_access_pkg;

    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;

    typedef enum logic [2:0] {
        MT_NONE = 3'd0,
        MT_W    = 3'd1,
        MT_H    = 3'd2,
        MT_HU   = 3'd3,
        MT_B    = 3'd4,
        MT_BU   = 3'd5
    } mem_type_e;

    typedef struct packed {
        mem_type_e mt;
        logic      is_store;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [5:0] opcode);
        mem_op_t op;
        op.mt       = MT_NONE;
        op.is_store = 1'b0;
        case (opcode)
            OP_SW:   begin op.mt = MT_W;  op.is_store = 1'b1; end
            OP_SH:   begin op.mt = MT_H;  op.is_store = 1'b1; end
            OP_SB:   begin op.mt = MT_B;  op.is_store = 1'b1; end
            OP_LW:   op.mt = MT_W;
            OP_LH:   op.mt = MT_H;
            OP_LHU:  op.mt = MT_HU;
            OP_LB:   op.mt = MT_B;
            OP_LBU:  op.mt = MT_BU;
            default: begin op.mt = MT_NONE; op.is_store = 1'b0; end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/memory_access_data_memory.sv
// Word-organised data memory: byte-enable write, async clear, combinational read.
// Optional store log is compiled in with DM_WRITE_LOG_EN.
module data_memory #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
`ifdef DM_WRITE_LOG_EN
    input  logic [31:0]   log_pc,
    input  logic [31:0]   log_addr,
`endif
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [0:(1 << AW)-1];
    logic [31:0] merged_s;

    assign rdata = mem_q[addr];

    // Merge enabled byte lanes of the write data over the current word.
    always_comb begin
        merged_s = mem_q[addr];
        for (int i = 0; i < 4; i++) begin
            merged_s[8*i +: 8] = be[i] ? wdata[8*i +: 8] : mem_q[addr][8*i +: 8];
        end
    end

    // Storage array; reset clears every word and discards an in-flight store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (we) begin
            mem_q[addr] <= merged_s;
        end
    end

`ifdef DM_WRITE_LOG_EN
    // Commit log of every store, reported with its full merged word.
    always @(posedge clk) begin
        if (!reset && we) begin
            $display("@%h: *%h <= %h", log_pc, log_addr, merged_s);
        end
    end
`endif

endmodule

// File: rtl/memory_access.sv
// MEM stage: decode, store-data forwarding, lane select/extension and MEM/WB register.
// Define DM_WRITE_LOG_EN to print every committed store.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int DM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC3,
    input  logic [31:0] Instr3,
    input  logic [31:0] Result3,
    input  logic [31:0] B3,
    input  logic [4:0]  WA3,
    input  logic [31:0] imm32_3,
    input  logic        ForwardRTM,
    input  logic [31:0] WD,
    output logic [31:0] PC4,
    output logic [31:0] Instr4,
    output logic [31:0] Result4,
    output logic [31:0] RD4,
    output logic [4:0]  WA4,
    output logic [31:0] imm32_4
);

    mem_op_t          op_s;
    logic [31:0]      sd_s;
    logic [31:0]      wdata_s;
    logic [31:0]      rdata_s;
    logic [3:0]       be_s;
    logic             we_s;
    logic [15:0]      half_s;
    logic [7:0]       byte_s;
    logic [DM_AW-1:0] widx_s;

    logic [31:0] pc4_d,     pc4_q;
    logic [31:0] instr4_d,  instr4_q;
    logic [31:0] result4_d, result4_q;
    logic [31:0] rd4_d,     rd4_q;
    logic [4:0]  wa4_d,     wa4_q;
    logic [31:0] imm4_d,    imm4_q;

    assign widx_s = Result3[DM_AW+1:2];

    // Store path: replicate the forwarded data across lanes, enable only the target bytes.
    always_comb begin
        op_s    = decode_op(Instr3[31:26]);
        sd_s    = ForwardRTM ? WD : B3;
        we_s    = op_s.is_store;
        be_s    = 4'b0000;
        wdata_s = sd_s;
        case (op_s.mt)
            MT_W: be_s = 4'b1111;
            MT_H: begin
                be_s    = Result3[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{sd_s[15:0]}};
            end
            MT_B: begin
                be_s    = 4'b0001 << Result3[1:0];
                wdata_s = {4{sd_s[7:0]}};
            end
            default: be_s = 4'b0000;
        endcase
    end

    data_memory #(.AW(DM_AW)) u_dmem (
        .clk      (clk),
        .reset    (reset),
        .we       (we_s),
        .be       (be_s),
        .addr     (widx_s),
        .wdata    (wdata_s),
`ifdef DM_WRITE_LOG_EN
        .log_pc   (PC3),
        .log_addr ({Result3[31:2], 2'b00}),
`endif
        .rdata    (rdata_s)
    );

    // Load path: pick the addressed half/byte and extend; non-loads yield zero.
    always_comb begin
        half_s = Result3[1] ? rdata_s[31:16] : rdata_s[15:0];
        case (Result3[1:0])
            2'd0:    byte_s = rdata_s[7:0];
            2'd1:    byte_s = rdata_s[15:8];
            2'd2:    byte_s = rdata_s[23:16];
            2'd3:    byte_s = rdata_s[31:24];
            default: byte_s = 8'd0;
        endcase
        rd4_d = 32'd0;
        if (op_s.is_store) begin
            rd4_d = 32'd0;
        end else begin
            case (op_s.mt)
                MT_W:    rd4_d = rdata_s;
                MT_H:    rd4_d = {{16{half_s[15]}}, half_s};
                MT_HU:   rd4_d = {16'd0, half_s};
                MT_B:    rd4_d = {{24{byte_s[7]}}, byte_s};
                MT_BU:   rd4_d = {24'd0, byte_s};
                default: rd4_d = 32'd0;
            endcase
        end
        pc4_d     = PC3;
        instr4_d  = Instr3;
        result4_d = Result3;
        wa4_d     = WA3;
        imm4_d    = imm32_3;
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc4_q     <= 32'd0;
            instr4_q  <= 32'd0;
            result4_q <= 32'd0;
            rd4_q     <= 32'd0;
            wa4_q     <= 5'd0;
            imm4_q    <= 32'd0;
        end else begin
            pc4_q     <= pc4_d;
            instr4_q  <= instr4_d;
            result4_q <= result4_d;
            rd4_q     <= rd4_d;
            wa4_q     <= wa4_d;
            imm4_q    <= imm4_d;
        end
    end

    assign PC4     = pc4_q;
    assign Instr4  = instr4_q;
    assign Result4 = result4_q;
    assign RD4     = rd4_q;
    assign WA4     = wa4_q;
    assign imm32_4 = imm4_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access against a byte-addressed reference memory.
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int DM_AW  = 10;
    localparam int NBYTES = 4 << DM_AW;

    logic        clk;
    logic        reset;
    logic [31:0] PC3, Instr3, Result3, B3, imm32_3, WD;
    logic [4:0]  WA3;
    logic        ForwardRTM;
    logic [31:0] PC4, Instr4, Result4, RD4, imm32_4;
    logic [4:0]  WA4;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ref_mem [0:NBYTES-1];

    memory_access #(.DM_AW(DM_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .PC3        (PC3),
        .Instr3     (Instr3),
        .Result3    (Result3),
        .B3         (B3),
        .WA3        (WA3),
        .imm32_3    (imm32_3),
        .ForwardRTM (ForwardRTM),
        .WD         (WD),
        .PC4        (PC4),
        .Instr4     (Instr4),
        .Result4    (Result4),
        .RD4        (RD4),
        .WA4        (WA4),
        .imm32_4    (imm32_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic ref_clear();
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'd0;
    endtask

    // Memory is modelled as plain bytes; byte address wraps at NBYTES.
    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a);
        int b, w, h;
        b = int'(a) & (NBYTES - 1);
        w = b & ~3;
        h = b & ~1;
        case (op)
            OP_LW:   return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
            OP_LH:   return {{16{ref_mem[h+1][7]}}, ref_mem[h+1], ref_mem[h]};
            OP_LHU:  return {16'd0, ref_mem[h+1], ref_mem[h]};
            OP_LB:   return {{24{ref_mem[b][7]}}, ref_mem[b]};
            OP_LBU:  return {24'd0, ref_mem[b]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd);
        int b, w, h;
        b = int'(a) & (NBYTES - 1);
        w = b & ~3;
        h = b & ~1;
        case (op)
            OP_SW: for (int i = 0; i < 4; i++) ref_mem[w+i] = sd[8*i +: 8];
            OP_SH: begin ref_mem[h] = sd[7:0]; ref_mem[h+1] = sd[15:8]; end
            OP_SB: ref_mem[b] = sd[7:0];
            default: ;
        endcase
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        logic [31:0] r;
        r = $urandom;
        return {op, r[25:0]};
    endfunction

    // One instruction through MEM; every MEM/WB output checked against the model.
    task automatic exec(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                        input logic [31:0] b, input logic fwd, input logic [31:0] wd);
        logic [31:0] pc, imm, exp_rd;
        logic [4:0]  wa;
        pc  = $urandom;
        imm = $urandom;
        wa  = 5'($urandom_range(0, 31));
        @(negedge clk);
        PC3 = pc; Instr3 = instr; Result3 = addr; B3 = b; WA3 = wa;
        imm32_3 = imm; ForwardRTM = fwd; WD = wd;
        exp_rd = ref_load(instr[31:26], addr);
        ref_store(instr[31:26], addr, fwd ? wd : b);
        @(posedge clk);
        #1;
        check({tag, "/RD4"}, RD4, exp_rd);
        check({tag, "/PC4"}, PC4, pc);
        check({tag, "/Instr4"}, Instr4, instr);
        check({tag, "/Result4"}, Result4, addr);
        check({tag, "/WA4"}, {27'd0, WA4}, {27'd0, wa});
        check({tag, "/imm32_4"}, imm32_4, imm);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "/PC4"}, PC4, 32'd0);
        check({tag, "/Instr4"}, Instr4, 32'd0);
        check({tag, "/Result4"}, Result4, 32'd0);
        check({tag, "/RD4"}, RD4, 32'd0);
        check({tag, "/WA4"}, {27'd0, WA4}, 32'd0);
        check({tag, "/imm32_4"}, imm32_4, 32'd0);
    endtask

    logic [5:0] ops [0:10];

    initial begin
        ops = '{OP_SW, OP_SH, OP_SB, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU,
                6'h00, 6'h0F, 6'h08};
        ref_clear();
        reset = 1'b1;
        PC3 = 32'h0000_1234; Instr3 = {OP_SW, 26'h0}; Result3 = 32'h10;
        B3 = 32'hFFFF_FFFF; WA3 = 5'd7; imm32_3 = 32'h55; ForwardRTM = 1'b0; WD = 32'd0;
        #18;
        check_zero_outputs("reset");
        Instr3 = 32'd0;
        #4 reset = 1'b0;

        exec("sw_10", mk(OP_SW), 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0);
        exec("lw_10", mk(OP_LW), 32'h10, 32'h0, 1'b0, 32'd0);
        check("lw_10_lit", RD4, 32'hDEAD_BEEF);
        exec("lw_14", mk(OP_LW), 32'h14, 32'h0, 1'b0, 32'd0);
        check("lw_14_lit", RD4, 32'd0);

        exec("sw_20", mk(OP_SW), 32'h20, 32'h1122_3344, 1'b0, 32'd0);
        exec("sb_23", mk(OP_SB), 32'h23, 32'h0000_00A5, 1'b0, 32'd0);
        exec("lw_20", mk(OP_LW), 32'h20, 32'h0, 1'b0, 32'd0);
        check("lw_20_lit", RD4, 32'hA522_3344);
        exec("lb_23", mk(OP_LB), 32'h23, 32'h0, 1'b0, 32'd0);
        check("lb_23_lit", RD4, 32'hFFFF_FFA5);
        exec("lbu_23", mk(OP_LBU), 32'h23, 32'h0, 1'b0, 32'd0);
        check("lbu_23_lit", RD4, 32'h0000_00A5);

        exec("sh_32", mk(OP_SH), 32'h32, 32'h0000_8001, 1'b0, 32'd0);
        exec("lh_32", mk(OP_LH), 32'h32, 32'h0, 1'b0, 32'd0);
        check("lh_32_lit", RD4, 32'hFFFF_8001);
        exec("lhu_30", mk(OP_LHU), 32'h30, 32'h0, 1'b0, 32'd0);
        check("lhu_30_lit", RD4, 32'd0);
        exec("lw_30", mk(OP_LW), 32'h30, 32'h0, 1'b0, 32'd0);
        check("lw_30_lit", RD4, 32'h8001_0000);

        exec("sw_fwd", mk(OP_SW), 32'h40, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678);
        exec("lw_fwd", mk(OP_LW), 32'h40, 32'h0, 1'b0, 32'd0);
        check("lw_fwd_lit", RD4, 32'h1234_5678);

        exec("sw_wrap", mk(OP_SW), 32'h0000_1004, 32'hCAFE_F00D, 1'b0, 32'd0);
        exec("lw_wrap", mk(OP_LW), 32'h4, 32'h0, 1'b0, 32'd0);
        check("lw_wrap_lit", RD4, 32'hCAFE_F00D);

        exec("addu", {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'h0000_0020, 32'h0, 1'b0, 32'd0);
        exec("bubble", 32'd0, 32'h0000_0010, 32'h0, 1'b0, 32'd0);

        // Asynchronous reset mid-cycle with a store in flight.
        exec("sw_8", mk(OP_SW), 32'h8, 32'h55AA_55AA, 1'b0, 32'd0);
        @(negedge clk);
        Instr3 = mk(OP_SW); Result3 = 32'h8; B3 = 32'h1111_1111; ForwardRTM = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        ref_clear();
        @(posedge clk);
        @(negedge clk);
        Instr3 = 32'd0;
        #2 reset = 1'b0;
        exec("lw_8_after_rst", mk(OP_LW), 32'h8, 32'h0, 1'b0, 32'd0);
        check("lw_8_after_rst_lit", RD4, 32'd0);
        exec("lw_20_after_rst", mk(OP_LW), 32'h20, 32'h0, 1'b0, 32'd0);

        // Random traffic concentrated in a few words, with random high address bits.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, r;
            r = $urandom;
            a = (r & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            exec("rand", mk(ops[$urandom_range(0, 10)]), a, $urandom,
                 1'($urandom_range(0, 1)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
